multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32 subset decoded by Control_Unit: R-type (0110011), load (0000011), store (0100011) and branch (1100011).
- Sequences one instruction over 3–5 states and drives the same datapath strobes as Control_Unit (Branch, MemRead, MemtoReg, Aluop, MemWrite, AluSrc, RegWrite), plus the multi-cycle controls (PCWrite, IRWrite, IorD, AluSrcA/B).
- Waits on a ready handshake from a shared instruction/data memory.
- Flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles a memory state waits for mem_ready before entering ERR.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- OpCode  in  7  IR[6:0]; valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepted the write or returned the read data this cycle.
- PCWrite  out  1  load PC.
- PCSrc  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  write-back select: 1 = MDR.
- RegWrite  out  1  register file write.
- Branch  out  1  high in BRANCH state.
- AluSrcA  out  1  0 = PC, 1 = rs1.
- AluSrcB  out  2  00 = rs2, 01 = const 4, 10 = immediate.
- Aluop  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- state_o  out  4  current state encoding, for debug.
- err  out  1  sticky error flag.
- err_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- State register, wait counter, err_code and retired are flops cleared asynchronously by reset.
  - Reset values: state = FETCH (0), wait = 0, err_code = 00, retired = 0.
- All strobe outputs are combinational decodes of state (plus mem_ready/Zero where noted), forced to 0 while reset is high.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ERR 9.
- Every strobe not listed for a state is 0.
- FETCH:
  - MemRead = 1, IorD = 0, AluSrcA = 0, AluSrcB = 01, Aluop = 00.
  - IRWrite = PCWrite = mem_ready, PCSrc = 0.
  - mem_ready -> DECODE; otherwise stay.
- DECODE: AluSrcA = 0, AluSrcB = 10, Aluop = 00 (precompute branch target into ALUOut). Next state by OpCode:
  - R-type -> EXEC
  - load or store -> MEMADR
  - branch -> BRANCH
  - any other value -> ERR with err_code = 01
- MEMADR: AluSrcA = 1, AluSrcB = 10, Aluop = 00. Load -> MEMRD; store -> MEMWR.
- MEMRD: MemRead = 1, IorD = 1. mem_ready -> MEMWB; otherwise stay.
- MEMWB: RegWrite = 1, MemtoReg = 1. Retires; -> FETCH.
- MEMWR: MemWrite = 1, IorD = 1. mem_ready -> FETCH and retires; otherwise stay.
- EXEC: AluSrcA = 1, AluSrcB = 00, Aluop = 10. -> ALUWB.
- ALUWB: RegWrite = 1, MemtoReg = 0. Retires; -> FETCH.
- BRANCH:
  - Branch = 1, AluSrcA = 1, AluSrcB = 00, Aluop = 01, PCSrc = 1, PCWrite = Zero.
  - Retires; -> FETCH regardless of Zero.
- Memory handshake:
  - MemRead/MemWrite stay high continuously until the cycle mem_ready = 1. The request is complete in that cycle.
  - mem_ready in any non-memory state is ignored.
- Timeout:
  - wait increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready = 0.
  - wait clears on every state change.
  - If wait == MEM_TIMEOUT-1 and mem_ready = 0 -> ERR with err_code = 10.
  - mem_ready = 1 in that same cycle wins: normal transition, no error.
- ERR: all strobes 0, err = 1, terminal until reset. err_code holds the first cause.
- Retire: retired += 1 on the clock edge leaving MEMWB, MEMWR (with ready), ALUWB or BRANCH. Wraps modulo 2^CNT_W.
- Instruction latency with zero-wait memory:
  - R-type 4 cycles, load 5, store 4, branch 3.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately: outputs go to 0 asynchronously, and FETCH starts on the first edge after release. No partial retire is counted.

Test Plan:
- Reset, then R-type 0110011 with mem_ready tied 1 -> states 0,1,6,7,0. RegWrite = 1 only in state 7 with MemtoReg = 0. retired = 1 after 4 cycles.
- Load 0000011, mem_ready low 3 cycles in MEMRD -> MemRead held 4 cycles with IorD = 1. MEMWB drives RegWrite = 1, MemtoReg = 1. Total 8 cycles; retired increments once.
- Branch 1100011 with Zero = 1, then again with Zero = 0 -> PCWrite = 1 with PCSrc = 1 in state 8 for the first; PCWrite = 0 for the second. Both return to FETCH; retired += 2.
- OpCode 0000000 in DECODE -> ERR (9), err = 1, err_code = 01. All strobes stay 0 for 20 cycles until reset.
- Store with mem_ready never asserted, MEM_TIMEOUT = 16 -> MemWrite high 16 cycles, then ERR with err_code = 10. Repeat with mem_ready on cycle 16 -> FETCH, no error.
- Assert reset during MEMWR with MemWrite = 1 -> MemWrite drops within the same cycle (asynchronous) and retired is unchanged. FETCH with MemRead = 1 on the first edge after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32 R-type/load/store/branch subset.
// Sequences one instruction over 3-5 states against a shared ready-handshake memory.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       OpCode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       Aluop,
  output logic [3:0]       state_o,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ERR    = 4'd9
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        code_next;
  logic              retire, mem_wait, timeout;

  assign mem_wait = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
  assign timeout  = mem_wait && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    code_next  = err_code;
    retire     = 1'b0;
    case (state)
      FETCH:  if (mem_ready) state_next = DECODE;
              else if (timeout) begin state_next = ERR; code_next = 2'b10; end
      DECODE: begin
        if (OpCode == OP_R)                         state_next = EXEC;
        else if ((OpCode == OP_LD) || (OpCode == OP_ST)) state_next = MEMADR;
        else if (OpCode == OP_BR)                   state_next = BRANCH;
        else begin state_next = ERR; code_next = 2'b01; end
      end
      MEMADR: state_next = (OpCode == OP_LD) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_next = MEMWB;
              else if (timeout) begin state_next = ERR; code_next = 2'b10; end
      MEMWB:  begin state_next = FETCH; retire = 1'b1; end
      MEMWR:  if (mem_ready) begin state_next = FETCH; retire = 1'b1; end
              else if (timeout) begin state_next = ERR; code_next = 2'b10; end
      EXEC:   state_next = ALUWB;
      ALUWB:  begin state_next = FETCH; retire = 1'b1; end
      BRANCH: begin state_next = FETCH; retire = 1'b1; end
      ERR:    state_next = ERR;
      default: state_next = FETCH;
    endcase
  end

  // Registered state: wait counter restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      err_code <= 2'b00;
      retired  <= '0;
    end else begin
      state    <= state_next;
      err_code <= code_next;
      if (state_next != state) wait_cnt <= '0;
      else if (mem_wait)       wait_cnt <= wait_cnt + 1'b1;
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Strobe decode; reset masks everything so an aborted access drops at once
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    AluSrcA  = 1'b0;
    AluSrcB  = 2'b00;
    Aluop    = 2'b00;
    if (!reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          AluSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: AluSrcB = 2'b10;
        MEMADR: begin AluSrcA = 1'b1; AluSrcB = 2'b10; end
        MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
        MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
        EXEC:   begin AluSrcA = 1'b1; Aluop = 2'b10; end
        ALUWB:  RegWrite = 1'b1;
        BRANCH: begin
          Branch  = 1'b1;
          AluSrcA = 1'b1;
          Aluop   = 2'b01;
          PCSrc   = 1'b1;
          PCWrite = Zero;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;
  assign err     = (state == ERR) && !reset;

endmodule
